// File: rtl/game_pkg.sv
// Shared definitions for the memory-game datapath.
// Contents: 7-segment glyphs (active-low, bit order gfedcba), the tick-enable
// bundle, level->playback-rate encoding, Fibonacci LFSR tap masks and a
// saturating 2-digit BCD adder.
package game_pkg;

    localparam logic [6:0] SEG_L = 7'b1000111;
    localparam logic [6:0] SEG_T = 7'b0000111;
    localparam logic [6:0] SEG_R = 7'b0101111;
    localparam logic [6:0] SEG_U = 7'b1000001;
    localparam logic [6:0] SEG_S = 7'b0010010;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;
    localparam logic [6:0] SEG_P = 7'b0001100;
    localparam logic [6:0] SEG_G = 7'b1000010;
    localparam logic [6:0] SEG_A = 7'b0001000;

    // Slow one-cycle enables, all derived from the 4 Hz base tick.
    typedef struct packed {
        logic hz2;
        logic hz1;
        logic hz05;
        logic hz025;
    } tick_t;

    // Level 0 is the slowest playback, level 3 the fastest.
    typedef enum logic [1:0] {
        LVL_0_25HZ = 2'd0,
        LVL_0_5HZ  = 2'd1,
        LVL_1HZ    = 2'd2,
        LVL_2HZ    = 2'd3
    } level_e;

    function automatic logic [6:0] seg_hex(input logic [3:0] d);
        case (d)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic rate_select(input logic [1:0] level, input tick_t t);
        case (level_e'(level))
            LVL_0_25HZ: return t.hz025;
            LVL_0_5HZ:  return t.hz05;
            LVL_1HZ:    return t.hz1;
            default:    return t.hz2;
        endcase
    endfunction

    // Fibonacci tap masks: bit k set means state bit k feeds the XOR.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return 32'h0000_00B8;
            24:      return 32'h00E1_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_B400;
        endcase
    endfunction

    // Two BCD digits plus a small increment; clamps at 99 instead of wrapping.
    function automatic logic [7:0] bcd_add_sat(input logic [7:0] p, input logic [3:0] inc);
        logic [4:0] u;
        logic [4:0] t;
        u = {1'b0, p[3:0]} + {1'b0, inc};
        t = {1'b0, p[7:4]};
        if (u > 5'd9) begin
            u = u - 5'd10;
            t = t + 5'd1;
        end
        if (u > 5'd9) begin
            u = u - 5'd10;
            t = t + 5'd1;
        end
        if (t > 5'd9) return 8'h99;
        return {t[3:0], u[3:0]};
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Slow tick enables for the game datapath. No derived clocks: every output is
// a one-cycle enable in the clock_50 domain.
// Ports:
//   clock_50  in   system clock
//   reset     in   synchronous, active-low
//   ticks     out  2 / 1 / 0.5 / 0.25 Hz one-cycle enables
module tick_gen
    import game_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic  clock_50,
    input  logic  reset,
    output tick_t ticks
);
    localparam int DIV = (CLK_HZ / 4 < 2) ? 2 : CLK_HZ / 4;
    localparam int PW  = $clog2(DIV);

    logic [PW-1:0] pre_cnt;
    logic [3:0]    div_cnt;
    logic          tick_4hz;

    assign tick_4hz = (pre_cnt == PW'(DIV - 1));

    always_ff @(posedge clock_50) begin
        if (!reset) begin
            pre_cnt <= '0;
            div_cnt <= '0;
        end else if (tick_4hz) begin
            pre_cnt <= '0;
            div_cnt <= div_cnt + 4'd1;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // Each slower rate fires on the 4 Hz tick that completes its divider span.
    always_comb begin
        ticks.hz2   = tick_4hz & div_cnt[0];
        ticks.hz1   = tick_4hz & (&div_cnt[1:0]);
        ticks.hz05  = tick_4hz & (&div_cnt[2:0]);
        ticks.hz025 = tick_4hz & (&div_cnt);
    end

endmodule

// File: rtl/game_datapath_param.sv
// Datapath for the key/LED memory game: setup latch, LFSR-built sequence,
// FPGA playback, user-entry checking, round counter, BCD points, countdown
// timer and the 6-digit HEX display mux.
// Ports:
//   clock_50, reset          clock; synchronous active-low reset
//   key[N_KEYS]              debounced push buttons, active-low
//   switch[8]                [7:6] level, [3:0] last round, [7:0] seed
//   r1 r2 e1 e2 e3 e4        controller strobes (new game, new round, setup,
//                            user phase, playback phase, round close)
//   sel                      display page select
//   hex0..hex5               seven-segment digits (active-low)
//   leds[N_KEYS]             one-hot playback LEDs
//   end_fpga end_user end_time win match   status back to the controller
// Control interface: there is no valid/ready handshake. Every strobe is
// level-sampled on each rising edge and acts for as long as it is held;
// status flags are registered and sticky until the matching clear strobe
// (r2 or r1), except match and end_time which are combinational views.
module game_datapath_param
    import game_pkg::*;
#(
    parameter int N_KEYS     = 4,
    parameter int MAX_ROUNDS = 16,
    parameter int LFSR_W     = 16,
    parameter int TIME_LIMIT = 9,
    parameter int CLK_HZ     = 50_000_000
) (
    input  logic              clock_50,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key,
    input  logic [7:0]        switch,
    input  logic              r1,
    input  logic              r2,
    input  logic              e1,
    input  logic              e2,
    input  logic              e3,
    input  logic              e4,
    input  logic              sel,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3,
    output logic [6:0]        hex4,
    output logic [6:0]        hex5,
    output logic [N_KEYS-1:0] leds,
    output logic              end_fpga,
    output logic              end_user,
    output logic              end_time,
    output logic              win,
    output logic              match
);
    localparam int KW = (N_KEYS > 2) ? $clog2(N_KEYS) : 1;
    localparam int IW = (MAX_ROUNDS > 2) ? $clog2(MAX_ROUNDS) : 1;
    localparam int SW = (LFSR_W > 16) ? LFSR_W : 16;
    localparam logic [31:0] TAPS_W = lfsr_taps(LFSR_W);
    localparam logic [LFSR_W-1:0] TAPS = TAPS_W[LFSR_W-1:0];

    tick_t ticks;
    tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .clock_50 (clock_50),
        .reset    (reset),
        .ticks    (ticks)
    );

    logic [1:0]        level;
    logic [3:0]        last;
    logic [KW-1:0]     seq [MAX_ROUNDS];
    logic [3:0]        p_idx;
    logic [3:0]        u_idx;
    logic [3:0]        round;
    logic [3:0]        time_left;
    logic [7:0]        points;
    logic              mismatch;
    logic [N_KEYS-1:0] key_prev;

    // Whole sequence is unrolled from the seed in the e1 cycle: entry i is
    // the low bits of the i-th LFSR state, state 0 being the seed itself.
    function automatic logic [MAX_ROUNDS*KW-1:0] build_seq(input logic [LFSR_W-1:0] seed_in);
        logic [LFSR_W-1:0] s;
        build_seq = '0;
        s = seed_in;
        for (int i = 0; i < MAX_ROUNDS; i++) begin
            build_seq[i*KW +: KW] = s[KW-1:0];
            s = {s[LFSR_W-2:0], ^(s & TAPS)};
        end
    endfunction

    function automatic logic [N_KEYS-1:0] onehot(input logic [KW-1:0] v);
        return N_KEYS'(1) << v;
    endfunction

    logic [SW-1:0]            seed_wide;
    logic [LFSR_W-1:0]        seed;
    logic [MAX_ROUNDS*KW-1:0] seq_next;
    logic [3:0]               last_next;
    logic [N_KEYS-1:0]        pressed;
    logic                     play_tick;

    assign seed_wide = SW'({switch, 8'hA5});
    // An all-zero state would lock the LFSR, so it is replaced by 1.
    assign seed      = (seed_wide[LFSR_W-1:0] == '0) ? LFSR_W'(1) : seed_wide[LFSR_W-1:0];
    assign seq_next  = build_seq(seed);
    assign last_next = (switch[3:0] > 4'(MAX_ROUNDS - 1)) ? 4'(MAX_ROUNDS - 1) : switch[3:0];
    // Press = falling edge on a key; simultaneous edges form one entry.
    assign pressed   = key_prev & ~key;
    assign play_tick = rate_select(level, ticks);

    assign match    = end_user & ~mismatch;
    assign end_time = (time_left == 4'd0);
    assign leds     = (e3 && !end_fpga) ? onehot(seq[p_idx[IW-1:0]]) : '0;

    always_ff @(posedge clock_50) begin
        if (!reset) begin
            level     <= '0;
            last      <= '0;
            p_idx     <= '0;
            u_idx     <= '0;
            round     <= '0;
            time_left <= 4'(TIME_LIMIT);
            points    <= '0;
            mismatch  <= 1'b0;
            end_fpga  <= 1'b0;
            end_user  <= 1'b0;
            win       <= 1'b0;
            key_prev  <= '0;
            for (int i = 0; i < MAX_ROUNDS; i++) seq[i] <= '0;
        end else begin
            key_prev <= key;

            // Setup only touches setup/sequence state, so it coexists with r1.
            if (e1) begin
                level <= switch[7:6];
                last  <= last_next;
                for (int i = 0; i < MAX_ROUNDS; i++) seq[i] <= seq_next[i*KW +: KW];
            end

            if (r1 || r2) begin
                p_idx     <= '0;
                u_idx     <= '0;
                mismatch  <= 1'b0;
                end_fpga  <= 1'b0;
                end_user  <= 1'b0;
                time_left <= 4'(TIME_LIMIT);
            end

            if (r1) begin
                round  <= '0;
                points <= '0;
                win    <= 1'b0;
            end else if (!r2) begin
                if (e3 && !end_fpga && play_tick) begin
                    if (p_idx == round) end_fpga <= 1'b1;
                    else                p_idx    <= p_idx + 4'd1;
                end

                if (e2 && !end_user && (|pressed)) begin
                    if (pressed != onehot(seq[u_idx[IW-1:0]])) mismatch <= 1'b1;
                    if (u_idx == round) end_user <= 1'b1;
                    else                u_idx    <= u_idx + 4'd1;
                end

                if (e2 && ticks.hz1 && time_left != 4'd0)
                    time_left <= time_left - 4'd1;

                if (e4) begin
                    if (match) points <= bcd_add_sat(points, {2'b00, level} + 4'd1);
                    if (round == last) win   <= 1'b1;
                    else               round <= round + 4'd1;
                end
            end
        end
    end

    always_comb begin
        hex5 = SEG_L;
        hex4 = seg_hex({2'b00, level});
        hex3 = SEG_T;
        hex2 = seg_hex(time_left);
        hex1 = SEG_R;
        hex0 = seg_hex(round);
        if (sel) begin
            if (win) begin
                hex5 = SEG_U;
                hex4 = SEG_S;
                hex3 = SEG_E;
                hex2 = SEG_R;
            end else begin
                hex5 = SEG_F;
                hex4 = SEG_P;
                hex3 = SEG_G;
                hex2 = SEG_A;
            end
            hex1 = seg_hex(points[7:4]);
            hex0 = seg_hex(points[3:0]);
        end
    end

endmodule
